// File: rtl/pbvi_pkg.sv
// Shared types and sizes for the PBVI pipeline stages.
package pbvi_pkg;

  localparam int unsigned N_POINTS = 16;
  localparam int unsigned N_STATES = 2;
  localparam int unsigned W        = 16;

  typedef logic [1:0] action_t;
  localparam action_t ACT_0 = 2'd0;
  localparam action_t ACT_1 = 2'd1;
  localparam action_t ACT_2 = 2'd2;

  typedef logic [W-1:0] alpha_t;

  typedef enum logic [1:0] {
    UPD_IDLE    = 2'd0,
    UPD_COMPARE = 2'd1,
    UPD_DECIDE  = 2'd2,
    UPD_DONE    = 2'd3
  } upd_state_e;

endpackage

// File: rtl/alpha_abs_diff.sv
// Unsigned absolute difference |a - b| without wraparound.
module alpha_abs_diff
  import pbvi_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d
);

  assign d = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/alpha_update.sv
// Closes a value-iteration pass: captures the winning alpha set, measures the
// largest element change against the committed set, then iterates or stops.
module alpha_update
  import pbvi_pkg::*;
#(
  parameter int unsigned  MAX_ITER = 64,
  parameter logic [W-1:0] EPS      = 16'd4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      alpha_valid,
  input  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0]  alpha_in,
  input  logic [N_POINTS-1:0][1:0]                  action_in,
  output logic [N_POINTS-1:0][N_STATES-1:0][W-1:0]  alpha_prev,
  output logic [N_POINTS-1:0][1:0]                  policy,
  output logic [7:0]                                iter_cnt,
  output logic [W-1:0]                              max_diff,
  output logic                                      busy,
  output logic                                      start_next,
  output logic                                      done
);

  localparam int unsigned N_ELEM   = N_POINTS * N_STATES;
  localparam int unsigned K_W      = $clog2(N_ELEM);
  localparam logic [7:0]  ITER_SAT = 8'hFF;

  upd_state_e state_q, state_d;
  logic [K_W-1:0] k_q;
  alpha_t run_max_q, run_max_d;
  alpha_t cur_elem, prev_elem, diff;
  logic [7:0] iter_next;
  logic converged, capped;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] shadow_alpha;
  logic [N_POINTS-1:0][1:0]                 shadow_action;

  alpha_abs_diff u_abs_diff (
    .a (cur_elem),
    .b (prev_elem),
    .d (diff)
  );

  // Next state, element mux (point = k>>1, component = k&1) and decision terms
  always_comb begin
    state_d   = state_q;
    cur_elem  = shadow_alpha[k_q[K_W-1:1]][k_q[0]];
    prev_elem = alpha_prev[k_q[K_W-1:1]][k_q[0]];
    run_max_d = (diff > run_max_q) ? diff : run_max_q;
    iter_next = (iter_cnt == ITER_SAT) ? iter_cnt : iter_cnt + 8'd1;
    converged = (iter_next >= 8'd2) && (run_max_q <= EPS);
    capped    = (iter_next == 8'(MAX_ITER));

    case (state_q)
      UPD_IDLE:    if (alpha_valid) state_d = UPD_COMPARE;
      UPD_COMPARE: if (k_q == K_W'(N_ELEM - 1)) state_d = UPD_DECIDE;
      UPD_DECIDE:  state_d = (converged || capped) ? UPD_DONE : UPD_IDLE;
      UPD_DONE:    state_d = UPD_DONE;
      default:     state_d = UPD_IDLE;
    endcase

    if (start) state_d = UPD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= UPD_IDLE;
      k_q           <= '0;
      run_max_q     <= '0;
      shadow_alpha  <= '0;
      shadow_action <= '0;
      alpha_prev    <= '0;
      policy        <= '0;
      iter_cnt      <= '0;
      max_diff      <= '0;
      busy          <= 1'b0;
      start_next    <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_next <= 1'b0;
      if (start) begin
        // New solve wipes history so the next pass counts as the first
        k_q        <= '0;
        run_max_q  <= '0;
        alpha_prev <= '0;
        policy     <= '0;
        iter_cnt   <= '0;
        max_diff   <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state_q)
          UPD_IDLE: begin
            if (alpha_valid) begin
              shadow_alpha  <= alpha_in;
              shadow_action <= action_in;
              k_q           <= '0;
              run_max_q     <= '0;
              busy          <= 1'b1;
            end
          end
          UPD_COMPARE: begin
            run_max_q <= run_max_d;
            k_q       <= k_q + K_W'(1);
          end
          UPD_DECIDE: begin
            alpha_prev <= shadow_alpha;
            policy     <= shadow_action;
            max_diff   <= run_max_q;
            iter_cnt   <= iter_next;
            busy       <= 1'b0;
            if (converged || capped) done <= 1'b1;
            else start_next <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alpha_update.sv
// Directed scoreboard bench for alpha_update (default instance and a MAX_ITER=4 instance).
module tb_alpha_update;
  import pbvi_pkg::*;

  localparam int unsigned AW = N_POINTS * N_STATES * W;

  typedef logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] vec_t;
  typedef logic [N_POINTS-1:0][1:0] act_t;
  typedef struct {
    logic [7:0]   iter;
    logic [W-1:0] mdiff;
    logic         sn;
    logic         dn;
    vec_t         alpha;
    act_t         pol;
  } exp_t;

  logic clk, rst;
  logic start_a, start_b, valid_a, valid_b;
  vec_t alpha_in;
  act_t action_in;
  vec_t prev_a, prev_b;
  act_t pol_a, pol_b;
  logic [7:0] iter_a, iter_b;
  logic [W-1:0] mdiff_a, mdiff_b;
  logic busy_a, busy_b, sn_a, sn_b, done_a, done_b;

  alpha_update #(.MAX_ITER(64), .EPS(16'd4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .alpha_valid(valid_a),
    .alpha_in(alpha_in), .action_in(action_in),
    .alpha_prev(prev_a), .policy(pol_a), .iter_cnt(iter_a), .max_diff(mdiff_a),
    .busy(busy_a), .start_next(sn_a), .done(done_a)
  );

  alpha_update #(.MAX_ITER(4), .EPS(16'd4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .alpha_valid(valid_b),
    .alpha_in(alpha_in), .action_in(action_in),
    .alpha_prev(prev_b), .policy(pol_b), .iter_cnt(iter_b), .max_diff(mdiff_b),
    .busy(busy_b), .start_next(sn_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  vec_t m_prev[2];
  logic [7:0] m_iter[2];
  int n_cmp = 0;
  int n_err = 0;
  int sn_cnt_b = 0;

  always @(negedge clk) if (sn_b) sn_cnt_b <= sn_cnt_b + 1;

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wide(string tag, logic [AW-1:0] obs, logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t fill(logic [W-1:0] val);
    vec_t v;
    for (int i = 0; i < N_POINTS; i++)
      for (int j = 0; j < N_STATES; j++) v[i][j] = val;
    return v;
  endfunction

  function automatic logic [W-1:0] absd(logic [W-1:0] a, logic [W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  task automatic push_exp(int sel, vec_t v, act_t p);
    exp_t e;
    logic [W-1:0] mx;
    logic [7:0] it;
    int cap;
    mx = '0;
    for (int i = 0; i < N_POINTS; i++)
      for (int j = 0; j < N_STATES; j++)
        if (absd(v[i][j], m_prev[sel][i][j]) > mx) mx = absd(v[i][j], m_prev[sel][i][j]);
    it = (m_iter[sel] == 8'hFF) ? 8'hFF : m_iter[sel] + 8'd1;
    cap = (sel == 1) ? 4 : 64;
    e.iter  = it;
    e.mdiff = mx;
    e.dn    = ((it >= 8'd2) && (mx <= 16'd4)) || (int'(it) == cap);
    e.sn    = !e.dn;
    e.alpha = v;
    e.pol   = p;
    sb_q.push_back(e);
    m_prev[sel] = v;
    m_iter[sel] = it;
  endtask

  task automatic model_clear(int sel);
    m_prev[sel] = '0;
    m_iter[sel] = '0;
  endtask

  // Drive one alpha_valid pulse; returns on the negedge after the sampling edge
  task automatic fire(int sel, vec_t v, act_t p, bit push);
    @(negedge clk);
    alpha_in  = v;
    action_in = p;
    if (sel == 1) valid_b = 1'b1; else valid_a = 1'b1;
    if (push) push_exp(sel, v, p);
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_check(int sel, int elapsed, string tag);
    int cyc;
    exp_t e;
    cyc = elapsed;
    while (!((sel == 1) ? (sn_b || done_b) : (sn_a || done_a)) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_latency"}, 32'(cyc), 32'd34);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_iter"},  32'((sel == 1) ? iter_b : iter_a), 32'(e.iter));
      check_val({tag, "_mdiff"}, 32'((sel == 1) ? mdiff_b : mdiff_a), 32'(e.mdiff));
      check_val({tag, "_sn"},    32'((sel == 1) ? sn_b : sn_a), 32'(e.sn));
      check_val({tag, "_done"},  32'((sel == 1) ? done_b : done_a), 32'(e.dn));
      check_val({tag, "_busy"},  32'((sel == 1) ? busy_b : busy_a), 32'd0);
      check_wide({tag, "_alpha"}, (sel == 1) ? prev_b : prev_a, e.alpha);
      check_val({tag, "_policy"}, (sel == 1) ? pol_b : pol_a, e.pol);
      if (e.sn) begin
        @(negedge clk);
        check_val({tag, "_sn_pulse"}, 32'((sel == 1) ? sn_b : sn_a), 32'd0);
      end
    end
  endtask

  task automatic check_cleared_a(string tag);
    check_val({tag, "_busy"}, 32'(busy_a), 32'd0);
    check_val({tag, "_iter"}, 32'(iter_a), 32'd0);
    check_val({tag, "_mdiff"}, 32'(mdiff_a), 32'd0);
    check_val({tag, "_sn"}, 32'(sn_a), 32'd0);
    check_val({tag, "_done"}, 32'(done_a), 32'd0);
    check_wide({tag, "_alpha"}, prev_a, '0);
    check_val({tag, "_policy"}, pol_a, 32'd0);
  endtask

  // Watch DUT A idle for n cycles: no start_next and no busy expected
  task automatic watch_idle_a(int n, string tag);
    int sn_seen, busy_seen;
    sn_seen = 0;
    busy_seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (sn_a) sn_seen++;
      if (busy_a) busy_seen++;
    end
    check_val({tag, "_sn_cnt"}, 32'(sn_seen), 32'd0);
    check_val({tag, "_busy_cnt"}, 32'(busy_seen), 32'd0);
  endtask

  initial begin
    vec_t v, x;
    act_t p;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    alpha_in = '0; action_in = '0;
    model_clear(0);
    model_clear(1);
    for (int i = 0; i < N_POINTS; i++) p[i] = 2'(i % 3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared_a("reset_a");
    check_val("reset_b_done", 32'(done_b), 32'd0);
    check_val("reset_b_iter", 32'(iter_b), 32'd0);

    // First pass below EPS must not converge
    v = fill(16'd3);
    fire(0, v, p, 1'b1);
    check_val("it1_busy", 32'(busy_a), 32'd1);
    wait_check(0, 1, "it1");
    check_val("it1_maxd_const", 32'(mdiff_a), 32'd3);

    v[5][1] = 16'd8;
    fire(0, v, p, 1'b1);
    wait_check(0, 1, "it2");
    check_val("it2_maxd_const", 32'(mdiff_a), 32'd5);

    v[2][0] = 16'd7;
    fire(0, v, p, 1'b1);
    wait_check(0, 1, "it3");
    check_val("it3_done_const", 32'(done_a), 32'd1);
    check_val("it3_iter_const", 32'(iter_a), 32'd3);

    // alpha_valid in DONE is ignored
    fire(0, fill(16'h0777), '1, 1'b0);
    watch_idle_a(40, "done_hold");
    check_val("done_hold_done", 32'(done_a), 32'd1);
    check_val("done_hold_iter", 32'(iter_a), 32'd3);
    check_wide("done_hold_alpha", prev_a, m_prev[0]);

    // start from DONE clears everything
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check_cleared_a("start_done");
    model_clear(0);

    // Large difference without wraparound, policy commit
    v = fill(16'd0);
    v[4][0] = 16'hFFF0;
    fire(0, v, p, 1'b1);
    wait_check(0, 1, "wrap1");
    v[4][0] = 16'h0010;
    p[7] = 2'b10;
    fire(0, v, p, 1'b1);
    wait_check(0, 1, "wrap2");
    check_val("wrap2_maxd_const", 32'(mdiff_a), 32'h0000FFE0);
    check_val("wrap2_pol7", 32'(pol_a[7]), 32'd2);

    // alpha_valid mid-COMPARE with different data is ignored
    x = v;
    x[9][1] = 16'd100;
    fire(0, x, p, 1'b1);
    repeat (9) @(negedge clk);
    check_val("midvalid_busy", 32'(busy_a), 32'd1);
    alpha_in = fill(16'h1234);
    action_in = '0;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    wait_check(0, 11, "midvalid");

    // start mid-COMPARE aborts the pass
    fire(0, fill(16'h0200), p, 1'b0);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_cleared_a("start_mid");
    model_clear(0);
    watch_idle_a(40, "start_mid");

    // start wins over alpha_valid in the same cycle
    @(negedge clk);
    alpha_in = fill(16'h0300);
    start_a = 1'b1;
    valid_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    valid_a = 1'b0;
    check_cleared_a("start_valid");
    watch_idle_a(40, "start_valid");

    // Following pass behaves as a first iteration
    fire(0, fill(16'd3), p, 1'b1);
    wait_check(0, 1, "restart1");
    check_val("restart1_iter_const", 32'(iter_a), 32'd1);
    check_val("restart1_sn_seen", 32'(done_a), 32'd0);

    // Iteration cap on the MAX_ITER=4 instance
    for (int k = 1; k <= 4; k++) begin
      fire(1, fill(16'(100 * k)), p, 1'b1);
      wait_check(1, 1, $sformatf("cap%0d", k));
    end
    check_val("cap_done_const", 32'(done_b), 32'd1);
    check_val("cap_iter_const", 32'(iter_b), 32'd4);
    check_val("cap_maxd_const", 32'(mdiff_b), 32'd100);
    check_val("cap_sn_pulses", 32'(sn_cnt_b), 32'd3);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alpha_update.md
# alpha_update

Iteration-closing stage of the PBVI pipeline. It sits directly downstream of the action-selection stage (step3). It captures the 16 winning alpha vectors and their actions, then compares them element by element against the previous iteration's set to find the largest change. It then either triggers another value-iteration pass via `start_next` or declares convergence via `done`. The committed `alpha_prev` set is the alpha input the upstream stages use on the next pass.

## Interface
Parameters:
- `N_POINTS`, 16, belief points / alpha vectors
- `N_STATES`, 2, components per alpha vector
- `W`, 16, value width, unsigned
- `MAX_ITER`, 64, iteration cap; must be ≥ 2
- `EPS`, 16'd4, convergence threshold on max absolute difference

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  pulse: begin a new solve; clears history
- `alpha_valid`  in  1  pulse: `alpha_in`/`action_in` final from step3
- `alpha_in`  in  [N_POINTS][N_STATES]×W  selected alpha vectors
- `action_in`  in  [N_POINTS]×2  selected action per point
- `alpha_prev`  out  [N_POINTS][N_STATES]×W  committed alpha set
- `policy`  out  [N_POINTS]×2  committed action per point
- `iter_cnt`  out  8  completed iterations
- `max_diff`  out  W  max |Δ| of the last completed compare
- `busy`  out  1  capture/compare/decide in progress
- `start_next`  out  1  one-cycle pulse: launch next iteration
- `done`  out  1  level: converged or capped

## Operation
- States: IDLE, COMPARE, DECIDE, DONE.
- Reset: state IDLE; `alpha_prev`, `policy`, `iter_cnt`, `max_diff`, `start_next`, `done`, `busy` all 0.
- `start` (any state): behaves as reset of history. It does not gate the cycle; `start_next` is 0 that cycle. `start` takes priority over `alpha_valid` in the same cycle.
- IDLE + `alpha_valid`:
  - latch `alpha_in`/`action_in` into a shadow buffer;
  - clear running max and index k;
  - go to COMPARE.
- COMPARE: one element per cycle, k = 0..31, flattened as point = k>>1, component = k&1.
  - d = |cur − prev|, computed unsigned as (a ≥ b ? a−b : b−a), W bits, no overflow.
  - running max = max(running max, d).
  - after k = 31, go to DECIDE.
- DECIDE: commit shadow to `alpha_prev`/`policy`; `max_diff` ← running max; `iter_cnt` += 1 (saturates at 255).
  - Converged when new `iter_cnt` ≥ 2 and running max ≤ EPS. The first iteration never converges, because its history is zero.
  - Converged, or new `iter_cnt` == MAX_ITER → DONE, `done`=1.
  - Otherwise pulse `start_next`, go to IDLE.
- DONE: holds all outputs. Only `start` or `rst` leave it; `alpha_valid` is ignored.
- `alpha_valid` while COMPARE/DECIDE: ignored, no capture. Upstream must not issue it before `start_next`.
- `alpha_in` may change freely after the capture cycle.

## Timing
- Cycle 0: `alpha_valid` sampled.
- Cycles 1–32: COMPARE; `busy`=1.
- Cycle 33: DECIDE; `busy`=1.
- Cycle 34: updated `alpha_prev`/`policy`/`iter_cnt`/`max_diff` visible. In the same cycle either `start_next`=1 (single cycle) or `done`=1. `busy`=0.
- Latency: alpha_valid → decision = 34 cycles. Throughput: one iteration per ≥ 35 cycles.
- `start` at cycle t: outputs cleared at t+1. `done`=0 from t+1.
- All outputs registered; no combinational input→output path.

## Structure
- Shared package `pbvi_pkg`:
  - `N_POINTS`, `N_STATES`, `W`
  - `action_t` (logic [1:0]) and action codes 0/1/2
  - `alpha_t` (W-bit value)
  - `upd_state_e` enum
- One sub-module, `alpha_abs_diff`: combinational unsigned |a−b| on W bits, reused by later stages.
- Single always_ff for state/counters/storage; a small always_comb for the next-state and diff mux.

## Test plan
- Reset then first `alpha_valid` with all `alpha_in` = 3 (< EPS) → cycle 34: `iter_cnt`=1, `max_diff`=3, `start_next`=1, `done`=0 (first-iteration rule).
- Second `alpha_valid` with one element 5 higher than `alpha_prev`, rest equal → `max_diff`=5, `start_next`=1. Third pass with max Δ=4 → `done`=1, `iter_cnt`=3.
- Element prev=0xFFF0, cur=0x0010 → d=0xFFE0, no wraparound; `max_diff`=0xFFE0. Also check `policy` matches `action_in` (e.g. 2'b10 at point 7).
- MAX_ITER=4, Δ always 100 → `done` at end of iteration 4, `start_next` pulses only after iterations 1–3.
- `alpha_valid` pulsed at cycle 10 of COMPARE with different data → ignored; committed set equals the first capture.
- `start` mid-COMPARE (and `start` with `alpha_valid` same cycle) → next cycle IDLE, all outputs 0, no capture. A subsequent `alpha_valid` behaves as first iteration.
